jtframe_dwnld_bridge: RTL
=========================

JTFRAME_DWNLD_BRIDGE -- requirements
Module: jtframe_dwnld_bridge

Interface
REQ-001 Parameter BA1_START, default 25'h0_400000, first byte address mapped to SDRAM bank 1.
REQ-002 Parameter BA2_START, default 25'h0_800000, first byte address mapped to bank 2.
REQ-003 Parameter BA3_START, default 25'h0_C00000, first byte address mapped to bank 3.
REQ-004 Parameter FIFO_DEPTH, default 4, number of pending prog writes (power of two, 2..16).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; the ports are clk_rom and rst_n.
REQ-006 clk_rom  in  1  sole clock; all ioctl and prog signals are sampled on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 downloading  in  1  ROM transfer active, from the SPI loader.
REQ-009 ioctl_addr  in  25  byte address of the current byte.
REQ-010 ioctl_data  in  8  byte value.
REQ-011 ioctl_wr  in  1  one-cycle strobe; each high cycle delivers one byte.
REQ-012 prog_addr  out  22  SDRAM word address within the bank.
REQ-013 prog_data  out  16  write data; bits [7:0] are the even byte and bits [15:8] the odd byte.
REQ-014 prog_mask  out  2  byte mask, active-low; bit 0 is the low byte and bit 1 is the high byte.
REQ-015 prog_ba  out  2  SDRAM bank.
REQ-016 prog_we  out  1  write request, held high until prog_rdy.
REQ-017 prog_rdy  in  1  one-cycle completion pulse from the SDRAM controller.
REQ-018 dwnld_busy  out  1  transfer not yet fully committed to SDRAM.
REQ-019 dwnld_ovf  out  1  sticky flag: a byte was lost because the FIFO was full.

Function
REQ-020 Bank decode SHALL be: addr>=BA3_START selects bank 3, else addr>=BA2_START selects bank 2, else addr>=BA1_START selects bank 1, else bank 0; offset = addr minus the bank start.
REQ-021 prog_addr SHALL be offset[22:1]; offset bits above 22 SHALL be discarded (wrap-around within the bank).
REQ-022 An even-offset byte SHALL be held in a single-entry pack register; it is not pushed to the FIFO immediately.
REQ-023 An odd-offset byte whose word and bank equal the held byte's SHALL merge with it: one entry is pushed with mask 2'b00 and data {odd,even}.
REQ-024 Any other byte arriving while a byte is held SHALL first push the held byte as a partial word, then be processed per REQ-022, REQ-023 or REQ-025.
REQ-025 An odd byte with no matching held byte SHALL push mask 2'b01 with data {byte,byte}.
REQ-026 A flushed even byte SHALL push mask 2'b10 with data {byte,byte}.
REQ-027 When a flush and a new push coincide, the flush SHALL take the current cycle and the new push the next; ioctl_wr is never asserted on consecutive cycles.
REQ-028 On the falling edge of downloading, a held byte SHALL be flushed.
REQ-029 The write FSM SHALL have two states.
- IDLE: with the FIFO non-empty, register the head entry onto prog_*, set prog_we, go to WRITE.
- WRITE: on prog_rdy, pop the entry, clear prog_we and return to IDLE.
- Consequence: at least one low cycle of prog_we between writes.
REQ-030 prog_we SHALL rise 2 cycles after the ioctl_wr that causes a push into an empty FIFO; prog_addr, prog_data, prog_mask and prog_ba SHALL stay stable while prog_we is high.
REQ-031 A push and a pop in the same cycle SHALL both take effect, with no change in occupancy.
REQ-032 A push while the FIFO is full and no pop occurs SHALL drop the entry and set dwnld_ovf.
REQ-033 dwnld_ovf SHALL clear on the rising edge of downloading.
REQ-034 dwnld_busy SHALL be the OR of: downloading, pack register valid, FIFO non-empty, prog_we.
REQ-035 prog_rdy SHALL be ignored in IDLE.

Reset
REQ-036 While rst_n is low, the block SHALL hold: prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0, dwnld_busy=0, dwnld_ovf=0; FIFO empty, pack register invalid, FSM in IDLE.
REQ-037 Reset mid-write SHALL drop prog_we asynchronously; pending entries are discarded.

Structure
REQ-038 Package jtframe_dwnld_pkg SHALL hold:
- the entry struct (ba, addr, data, mask);
- the FSM state enum;
- mask constants MASK_WORD, MASK_LO and MASK_HI.
REQ-039 The FIFO SHALL be the sub-module jtframe_dwnld_fifo, with synchronous push/pop and full/empty outputs.

Verification
REQ-040 Bytes 8'h12 @0 then 8'h34 @1 -> one write: ba=0, addr=0, data=16'h3412, mask=2'b00.
REQ-041 Byte 8'hAA @25'h400005 alone, then downloading falls -> one write: ba=1, addr=2, data=16'hAAAA, mask=2'b01.
REQ-042 Byte 8'h55 @4, then 8'h66 @8 -> writes in order: (addr=2, mask=2'b10, data=16'h5555), then (addr=4, mask=2'b10, data=16'h6666) after the flush at downloading fall.
REQ-043 prog_rdy withheld while 12 bytes are sent to consecutive addresses (6 entries, FIFO_DEPTH=4) -> dwnld_ovf=1, exactly 4 writes after prog_rdy resumes, dwnld_ovf cleared by the next downloading rise.
REQ-044 rst_n pulled low while prog_we=1 with 3 entries queued -> prog_we=0 at once, dwnld_busy=0, and no writes after reset is released.
REQ-045 Streaming 0x1000 bytes with prog_rdy returned 3 cycles after each prog_we -> 0x800 writes with correct data, no overflow, and dwnld_busy falling only after the last prog_rdy.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_dwnld_pkg
// Description : Shared types, lane masks and bank decode for the ROM download
//               bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package jtframe_dwnld_pkg;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } dwnld_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } dwnld_state_t;

    // Active-low lane masks: LO writes only the even byte, HI only the odd one.
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic        odd;
    } dwnld_loc_t;

    // Offset is truncated to 23 bits so addresses past a bank wrap inside it.
    function automatic dwnld_loc_t dwnld_decode(
        input logic [24:0] addr,
        input logic [24:0] ba1,
        input logic [24:0] ba2,
        input logic [24:0] ba3
    );
        dwnld_loc_t  loc;
        logic [22:0] offset;
        if (addr >= ba3) begin
            loc.ba = 2'd3;
            offset = 23'(addr - ba3);
        end else if (addr >= ba2) begin
            loc.ba = 2'd2;
            offset = 23'(addr - ba2);
        end else if (addr >= ba1) begin
            loc.ba = 2'd1;
            offset = 23'(addr - ba1);
        end else begin
            loc.ba = 2'd0;
            offset = 23'(addr);
        end
        loc.addr = offset[22:1];
        loc.odd  = offset[0];
        return loc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dwnld_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_dwnld_fifo
// Description : Small synchronous FIFO of pending SDRAM write entries.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  dwnld_entry_t i_din,
    input  logic         i_pop,
    output dwnld_entry_t o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    dwnld_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_dwnld_bridge.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_dwnld_bridge
// Description : Packs ioctl download bytes into 16-bit SDRAM prog writes.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dwnld_bridge
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START  = 25'h0_400000,
    parameter logic [24:0] BA2_START  = 25'h0_800000,
    parameter logic [24:0] BA3_START  = 25'h0_C00000,
    parameter int          FIFO_DEPTH = 4
)(
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        dwnld_ovf
);
    dwnld_loc_t   w_loc;
    dwnld_entry_t w_held, w_single, w_push_entry, w_head, r_pend;
    dwnld_state_t r_state;
    logic         r_pack_valid, r_pend_valid, r_dl_d, r_flush_req;
    logic [1:0]   r_pack_ba;
    logic [21:0]  r_pack_addr;
    logic [7:0]   r_pack_byte;
    logic         w_fall, w_rise, w_match, w_push, w_pop, w_drop;
    logic         w_fifo_full, w_fifo_empty;

    assign w_loc    = dwnld_decode(ioctl_addr, BA1_START, BA2_START, BA3_START);
    assign w_fall   = r_dl_d & ~downloading;
    assign w_rise   = downloading & ~r_dl_d;
    assign w_match  = r_pack_valid & w_loc.odd & (w_loc.ba == r_pack_ba)
                    & (w_loc.addr == r_pack_addr);
    assign w_held   = '{ba: r_pack_ba, addr: r_pack_addr,
                        data: {r_pack_byte, r_pack_byte}, mask: MASK_LO};
    assign w_single = '{ba: w_loc.ba, addr: w_loc.addr,
                        data: {ioctl_data, ioctl_data}, mask: MASK_HI};
    assign w_pop    = (r_state == ST_WRITE) & prog_rdy;
    assign w_drop   = w_push & w_fifo_full & ~w_pop;

    always_comb begin
        w_push       = 1'b0;
        w_push_entry = w_held;
        if (ioctl_wr) begin
            if (w_match) begin
                w_push       = 1'b1;
                w_push_entry = '{ba: r_pack_ba, addr: r_pack_addr,
                                 data: {ioctl_data, r_pack_byte}, mask: MASK_WORD};
            end else if (r_pack_valid) begin
                w_push       = 1'b1;
            end else if (w_loc.odd) begin
                w_push       = 1'b1;
                w_push_entry = w_single;
            end
        end else if (r_pend_valid) begin
            w_push       = 1'b1;
            w_push_entry = r_pend;
        end else if ((w_fall | r_flush_req) & r_pack_valid) begin
            w_push       = 1'b1;
        end
    end

    // Pack register, deferred push after a flush, and end-of-download flush.
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_d       <= 1'b0;
            r_flush_req  <= 1'b0;
            r_pack_valid <= 1'b0;
            r_pack_ba    <= '0;
            r_pack_addr  <= '0;
            r_pack_byte  <= '0;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            dwnld_ovf    <= 1'b0;
        end else begin
            r_dl_d       <= downloading;
            r_pend_valid <= 1'b0;
            if (ioctl_wr) begin
                r_flush_req <= w_fall;
                if (w_match) begin
                    r_pack_valid <= 1'b0;
                end else if (!w_loc.odd) begin
                    r_pack_valid <= 1'b1;
                    r_pack_ba    <= w_loc.ba;
                    r_pack_addr  <= w_loc.addr;
                    r_pack_byte  <= ioctl_data;
                end else begin
                    r_pack_valid <= 1'b0;
                    if (r_pack_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend       <= w_single;
                    end
                end
            end else begin
                r_flush_req <= 1'b0;
                if (w_fall | r_flush_req) begin
                    r_pack_valid <= 1'b0;
                end
            end
            if (w_rise) begin
                dwnld_ovf <= 1'b0;
            end
            if (w_drop) begin
                dwnld_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_ba   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        prog_ba   <= w_head.ba;
                        prog_addr <= w_head.addr;
                        prog_data <= w_head.data;
                        prog_mask <= w_head.mask;
                        prog_we   <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst_n so busy reads low for the whole reset, even mid-download.
    assign dwnld_busy = rst_n & (downloading | r_pack_valid | r_pend_valid
                               | ~w_fifo_empty | prog_we);

    jtframe_dwnld_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_rom),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
`default_nettype wire
